// File: rtl/vec_mat_mult_1xn.sv
// rtl/vec_mat_mult_1xn.sv - row-vector by matrix multiplier, Res = x^T * A, one matrix row per enabled cycle
//
// Purpose: serial 1xN by NxN fixed-point multiply for the Kalman datapath.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clk_en     clock enable; all state advances only when high
//   startMult  compute request, accepted only in IDLE
//   x          row vector operand, signed Q(intDigits).(WIDTH-intDigits)
//   A          matrix operand, A[row][col]
//   Res        result, Res[j] = sum_i x[i]*A[i][j], modular WIDTH-bit wrap
//   endMult    result-valid strobe, high for exactly one enabled cycle
module vec_mat_mult_1xn #(
    parameter int WIDTH     = 16,
    parameter int nos       = 4,
    parameter int intDigits = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             startMult,
    input  logic [WIDTH-1:0] x   [0:nos-1],
    input  logic [WIDTH-1:0] A   [0:nos-1][0:nos-1],
    output logic [WIDTH-1:0] Res [0:nos-1],
    output logic             endMult
);

    localparam int IW      = (nos > 1) ? $clog2(nos) : 1;
    localparam int INTBITS = 2*WIDTH - intDigits - 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(nos - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ONMULT  = 2'd1,
        ENDMULT = 2'd2
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_res [0:nos-1];
    logic [WIDTH-1:0] w_term [0:nos-1];

    // Rescale the double-width product back to the operand format. Keeping the
    // product MSB as the sign and dropping low fraction bits gives floor rounding.
    function automatic logic [WIDTH-1:0] rescale(input logic signed [2*WIDTH-1:0] p);
        logic [WIDTH-1:0] t;
        t = {p[2*WIDTH-1], p[INTBITS-1 -: WIDTH-1]};
        return t;
    endfunction

    // Products for the row currently selected by the index.
    always_comb begin
        for (int j = 0; j < nos; j++) begin
            w_term[j] = rescale($signed(x[r_idx]) * $signed(A[r_idx][j]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            for (int j = 0; j < nos; j++) r_res[j] <= '0;
        end else if (clk_en) begin
            case (r_state)
                IDLE: begin
                    r_idx <= '0;
                    if (startMult) begin
                        r_state <= ONMULT;
                        for (int j = 0; j < nos; j++) r_res[j] <= '0;
                    end
                end
                ONMULT: begin
                    for (int j = 0; j < nos; j++) r_res[j] <= r_res[j] + w_term[j];
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= ENDMULT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ENDMULT: begin
                    r_idx   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_idx   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign endMult = (r_state == ENDMULT);
    assign Res     = r_res;

endmodule

// File: tb/tb_vec_mat_mult_1xn.sv
// tb/tb_vec_mat_mult_1xn.sv - directed self-checking bench for vec_mat_mult_1xn
module tb_vec_mat_mult_1xn;

    localparam int W = 16;
    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         clk_en;
    logic         startMult;
    logic [W-1:0] x   [0:N-1];
    logic [W-1:0] A   [0:N-1][0:N-1];
    logic [W-1:0] Res [0:N-1];
    logic         endMult;

    logic [W-1:0] exp_res [0:N-1];
    int pass_cnt = 0;
    int tot_cnt  = 0;

    vec_mat_mult_1xn #(.WIDTH(W), .nos(N), .intDigits(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .startMult (startMult),
        .x         (x),
        .A         (A),
        .Res       (Res),
        .endMult   (endMult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ops();
        for (int i = 0; i < N; i++) begin
            x[i] = '0;
            for (int j = 0; j < N; j++) A[i][j] = '0;
        end
    endtask

    task automatic chk_res(input string tag);
        for (int j = 0; j < N; j++) chk($sformatf("%s res[%0d]", tag, j), {16'h0, Res[j]}, {16'h0, exp_res[j]});
    endtask

    // Accept at edge E, endMult must appear only at E+N and last one cycle.
    task automatic run_mult(input string tag);
        startMult = 1'b1;
        tick();
        startMult = 1'b0;
        for (int k = 1; k < N; k++) begin
            tick();
            chk($sformatf("%s end_early%0d", tag, k), {31'h0, endMult}, 32'h0);
        end
        tick();
        chk({tag, " end_on"}, {31'h0, endMult}, 32'h1);
        chk_res(tag);
        tick();
        chk({tag, " end_off"}, {31'h0, endMult}, 32'h0);
    endtask

    task automatic setup_identity();
        clear_ops();
        for (int i = 0; i < N; i++) begin
            A[i][i] = 16'h0010;
            x[i]    = 16'(16 * (i + 1));
            exp_res[i] = 16'(16 * (i + 1));
        end
    endtask

    task automatic setup_colsum();
        for (int i = 0; i < N; i++) begin
            x[i] = 16'(16 * (i + 1));
            for (int j = 0; j < N; j++) A[i][j] = 16'h0010;
            exp_res[i] = 16'h00A0;
        end
    endtask

    int en_cnt;
    int rise [0:2];
    int nrise;
    logic prev_end;

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; startMult = 1'b0;
        clear_ops();
        tick();
        tick();
        chk("reset end", {31'h0, endMult}, 32'h0);
        for (int j = 0; j < N; j++) exp_res[j] = '0;
        chk_res("reset");
        rst_n = 1'b1;
        tick();

        // 1 identity
        setup_identity();
        run_mult("ident");

        // 2 column sums and transposed indexing
        setup_colsum();
        run_mult("colsum");
        for (int i = 0; i < N; i++) begin
            x[i] = 16'h0010;
            for (int j = 0; j < N; j++) A[i][j] = 16'(16 * (j + 1));
        end
        exp_res[0] = 16'h0040; exp_res[1] = 16'h0080; exp_res[2] = 16'h00C0; exp_res[3] = 16'h0100;
        run_mult("transp");

        // 3 sign and truncation
        clear_ops();
        x[0] = 16'hFFF0;
        for (int j = 0; j < N; j++) begin A[0][j] = 16'h0020; exp_res[j] = 16'hFFE0; end
        run_mult("neg");
        clear_ops();
        x[0] = 16'hFFFF; A[0][0] = 16'h0001;
        for (int j = 0; j < N; j++) exp_res[j] = '0;
        exp_res[0] = 16'hFFFF;
        run_mult("floor_neg");
        x[0] = 16'h0001;
        exp_res[0] = 16'h0000;
        run_mult("floor_pos");

        // 4 clock-enable gating, accept on an enabled edge
        setup_identity();
        en_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            clk_en    = (k % 2 == 0);
            startMult = (k == 0);
            tick();
            if (endMult) en_cnt++;
        end
        clk_en = 1'b1;
        startMult = 1'b0;
        chk("gate end_len", en_cnt, 2);
        chk_res("gate");

        // 5 startMult held high: one compute per IDLE visit, period N+2
        setup_identity();
        nrise = 0;
        prev_end = 1'b0;
        startMult = 1'b1;
        for (int k = 0; k < 18; k++) begin
            tick();
            if (endMult && !prev_end && nrise < 3) begin rise[nrise] = k; nrise++; end
            prev_end = endMult;
            if (k == 6) chk("hold clear", {16'h0, Res[0]}, 32'h0);
            if (k == 4 || k == 10) chk_res($sformatf("hold%0d", k));
        end
        startMult = 1'b0;
        chk("hold nrise", nrise, 3);
        chk("hold first", rise[0], 4);
        chk("hold period1", rise[1] - rise[0], N + 2);
        chk("hold period2", rise[2] - rise[1], N + 2);
        tick();
        tick();

        // 6 reset in the middle of a compute
        setup_colsum();
        startMult = 1'b1;
        tick();
        startMult = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst end", {31'h0, endMult}, 32'h0);
        chk("mid_rst res0", {16'h0, Res[0]}, 32'h0);
        chk("mid_rst res3", {16'h0, Res[3]}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        run_mult("after_rst");

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
